dcm_freq_programmer: RTL



---
 rtl/dcm_freq_pkg.sv | 45 ++++
 rtl/option_sync_filter.sv | 44 ++++
 rtl/dcm_freq_programmer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dcm_freq_pkg.sv
// Shared constants for the DCM_CLKGEN run-time reprogramming controller:
// M-1/D-1 tables, LoadD/LoadM command prefixes, frame lengths and FSM encoding.
package dcm_freq_pkg;

    // CLKFX = 50 MHz * M/D; packed with option 7 in the top byte.
    localparam logic [63:0] D_MINUS1_TAB = {8'd25, 8'd24, 8'd7, 8'd17, 8'd4, 8'd11, 8'd6, 8'd24};
    localparam logic [63:0] M_MINUS1_TAB = {8'd16, 8'd15, 8'd4, 8'd10, 8'd2, 8'd6, 8'd3, 8'd13};

    localparam logic [1:0] LOADD = 2'b01;
    localparam logic [1:0] LOADM = 2'b11;

    localparam logic [3:0] LOAD_LAST = 4'd9;
    localparam logic [3:0] GAP_LAST  = 4'd1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD_D    = 3'd1;
    localparam logic [2:0] ST_GAP_D     = 3'd2;
    localparam logic [2:0] ST_LOAD_M    = 3'd3;
    localparam logic [2:0] ST_GAP_M     = 3'd4;
    localparam logic [2:0] ST_GO        = 3'd5;
    localparam logic [2:0] ST_WAIT_DONE = 3'd6;

    typedef struct packed {
        logic en;
        logic data;
    } prog_bus_t;

    function automatic logic [7:0] d_minus1(input logic [2:0] opt);
        return D_MINUS1_TAB[{opt, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] m_minus1(input logic [2:0] opt);
        return M_MINUS1_TAB[{opt, 3'b000} +: 8];
    endfunction

    // Bit idx of a 10-bit load word: two prefix bits, then value LSB first.
    function automatic logic load_bit(input logic [1:0] prefix, input logic [7:0] value,
                                      input logic [3:0] idx);
        if (idx < 4'd2) begin
            return prefix[idx[0]];
        end
        return value[3'(idx - 4'd2)];
    endfunction

endpackage

// File: rtl/option_sync_filter.sv
// Brings pll_option into the clk domain and reports it only after it has held
// steady for STABLE_CYCLES consecutive samples.
module option_sync_filter #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opt_in,
    output logic [2:0] opt_stable,
    output logic       opt_valid
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    last;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            last  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= opt_in;
            sync2 <= sync1;
            if (sync2 != last) begin
                last <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // opt_valid qualifies opt_stable; there is no ready, the consumer samples
    // the pair whenever it is able to act, and valid drops on any new change.
    assign opt_stable = last;
    assign opt_valid  = (sync2 == last) && (cnt == CNT_MAX);

endmodule

// File: rtl/dcm_freq_programmer.sv
// Applies stable pll_option values to the DCM_CLKGEN through PROGEN/PROGDATA as
// complete LoadD/LoadM/GO frames, then waits for PROGDONE with a timeout.
module dcm_freq_programmer
    import dcm_freq_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int DONE_TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] pll_option,
    input  logic       prog_done,
    output logic       prog_en,
    output logic       prog_data,
    output logic       busy,
    output logic [2:0] applied_option,
    output logic       error
);

    localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(DONE_TIMEOUT - 1);

    logic [2:0]    state;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] wait_cnt;
    logic [2:0]    target;
    logic          retry_block;
    logic [2:0]    opt_stable;
    logic          opt_valid;
    logic          start_frame;
    prog_bus_t     bus;

    option_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .opt_in    (pll_option),
        .opt_stable(opt_stable),
        .opt_valid (opt_valid)
    );

    // A timed-out option stays blocked until the filter sees a fresh change.
    assign start_frame = opt_valid && (opt_stable != applied_option)
                         && !(retry_block && (opt_stable == target));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            wait_cnt       <= '0;
            target         <= '0;
            applied_option <= '0;
            error          <= 1'b0;
            retry_block    <= 1'b0;
        end else begin
            if (!opt_valid) begin
                retry_block <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    wait_cnt <= '0;
                    if (start_frame) begin
                        target <= opt_stable;
                        state  <= ST_LOAD_D;
                    end
                end
                ST_LOAD_D: begin
                    if (bit_cnt == LOAD_LAST) begin
                        bit_cnt <= '0;
                        state   <= ST_GAP_D;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_GAP_D: begin
                    if (bit_cnt == GAP_LAST) begin
                        bit_cnt <= '0;
                        state   <= ST_LOAD_M;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_LOAD_M: begin
                    if (bit_cnt == LOAD_LAST) begin
                        bit_cnt <= '0;
                        state   <= ST_GAP_M;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_GAP_M: begin
                    if (bit_cnt == GAP_LAST) begin
                        bit_cnt <= '0;
                        state   <= ST_GO;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_GO: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (prog_done) begin
                        applied_option <= target;
                        error          <= 1'b0;
                        retry_block    <= 1'b0;
                        state          <= ST_IDLE;
                    end else if (wait_cnt == TO_LAST) begin
                        error       <= 1'b1;
                        retry_block <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // PROGDATA is sampled by the DCM on the same clk, so a decoded output is safe.
    always_comb begin
        bus = '0;
        case (state)
            ST_LOAD_D: begin
                bus.en   = 1'b1;
                bus.data = load_bit(LOADD, d_minus1(target), bit_cnt);
            end
            ST_LOAD_M: begin
                bus.en   = 1'b1;
                bus.data = load_bit(LOADM, m_minus1(target), bit_cnt);
            end
            ST_GO: begin
                bus.en   = 1'b1;
                bus.data = 1'b0;
            end
            default: bus = '0;
        endcase
    end

    assign prog_en   = bus.en;
    assign prog_data = bus.data;
    assign busy      = (state != ST_IDLE);

endmodule
